// File: rtl/lisp_pkg.sv
// Shared definitions for the Lisp evaluator core and its heap memory.
//
// Contents:
//   ADDR_W / DATA_W   heap geometry (4096 words of 16 bits)
//   TAG_MSB/TAG_LSB   tag field of a tagged word ([14:12])
//   IDX_MSB           top bit of the index/payload field ([11:0])
//   tag_t             word type tags
//   mem_state_t       heap read sequencer states
//   word_tag/word_idx field extraction helpers
package lisp_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;
  localparam int TAG_MSB = 14;
  localparam int TAG_LSB = 12;
  localparam int IDX_MSB = 11;

  typedef enum logic [2:0] {
    TYPE_NUMBER = 3'b000,
    TYPE_SYMBOL = 3'b001,
    TYPE_CONS   = 3'b010,
    TYPE_NIL    = 3'b011,
    TYPE_FUNC   = 3'b100
  } tag_t;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_t;

  function automatic tag_t word_tag(input logic [DATA_W-1:0] w);
    return tag_t'(w[TAG_MSB:TAG_LSB]);
  endfunction

  function automatic logic [IDX_MSB:0] word_idx(input logic [DATA_W-1:0] w);
    return w[IDX_MSB:0];
  endfunction

endpackage

// File: rtl/lisp_memory_mem_array.sv
// mem_array: single-port synchronous heap array (block-RAM inferable).
//
// Word i holds i truncated to DATA_W bits at power-up (identity image).
// Contents are never cleared by reset; the read register has no reset
// either so the array maps onto a plain block RAM.
//
// Ports:
//   clk      in   1       rising-edge clock
//   we       in   1       write enable (tied low for a read-only ROM)
//   addr     in   ADDR_W  word address for both read and write
//   wr_data  in   DATA_W  write data
//   rd_data  out  DATA_W  registered read data: mem[addr] from the previous edge
module mem_array #(
  parameter int    ADDR_W    = 12,
  parameter int    DATA_W    = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  function automatic mem_t init_image();
    mem_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = DATA_W'(i);
    end
    return img;
  endfunction

  mem_t mem_reg = init_image();

  logic [DATA_W-1:0] rd_data_reg;

  // Read-first: a read at the address being written returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= wr_data;
    end
    rd_data_reg <= mem_reg[addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/lisp_memory.sv
// lisp_memory: word-addressed heap for the Lisp evaluator core.
//
// A one-cycle req with addr_in starts a read; READ_LATENCY cycles later the
// word is presented on data_out together with a one-cycle data_ready strobe.
// Requests arriving while a read is in flight are dropped.
//
// Optional feature (macro MEM_WRITE_EN): adds wr_req/wr_data. In IDLE a
// write strobe stores wr_data at addr_in in one cycle and takes priority
// over a simultaneous read request. Without the macro the array is a ROM.
//
// Ports:
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous active-high reset
//   req         in   1       read request pulse
//   addr_in     in   ADDR_W  word address, sampled with req (and wr_req)
//   wr_req      in   1       write strobe            (MEM_WRITE_EN only)
//   wr_data     in   DATA_W  write data              (MEM_WRITE_EN only)
//   data_ready  out  1       one-cycle strobe: data_out holds fresh data
//   data_out    out  DATA_W  read data, held until the next completed read
//   busy        out  1       high while a read is in flight
module lisp_memory #(
  parameter int    ADDR_W       = lisp_pkg::ADDR_W,
  parameter int    DATA_W       = lisp_pkg::DATA_W,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr_in,
`ifdef MEM_WRITE_EN
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  import lisp_pkg::*;

  // Latency is limited to 1..7, so a 3-bit counter covers it.
  localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

  mem_state_t        state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              data_ready_reg, data_ready_next;
  logic [DATA_W-1:0] data_out_reg, data_out_next;
  logic              busy_reg, busy_next;

  logic              wr_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

`ifdef MEM_WRITE_EN
  assign wr_fire     = wr_req;
  assign mem_wr_data = wr_data;
`else
  assign wr_fire     = 1'b0;
  assign mem_wr_data = '0;
`endif

  // In IDLE the array is addressed straight from addr_in so the word is
  // already sitting in the array's read register one edge after acceptance;
  // that keeps a latency of 1 achievable. While BUSY the latched address
  // keeps the read register stable until the final cycle.
  assign mem_addr = (state_reg == MEM_IDLE) ? addr_in : addr_reg;

  mem_array #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .INIT_FILE(INIT_FILE)
  ) u_mem_array (
    .clk    (clk),
    .we     (mem_we),
    .addr   (mem_addr),
    .wr_data(mem_wr_data),
    .rd_data(mem_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= MEM_IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      data_ready_reg <= 1'b0;
      data_out_reg   <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      data_ready_reg <= data_ready_next;
      data_out_reg   <= data_out_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    data_ready_next = 1'b0;
    data_out_next   = data_out_reg;
    busy_next       = busy_reg;
    mem_we          = 1'b0;

    case (state_reg)
      MEM_IDLE: begin
        if (wr_fire) begin
          // Write wins over a simultaneous read; the read is simply lost.
          mem_we = 1'b1;
        end else if (req) begin
          addr_next  = addr_in;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        if (cnt_reg == LAST_CNT) begin
          data_out_next   = mem_rd_data;
          data_ready_next = 1'b1;
          busy_next       = 1'b0;
          cnt_next        = '0;
          state_next      = MEM_IDLE;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      default: begin
        state_next = MEM_IDLE;
        busy_next  = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  assign data_ready = data_ready_reg;
  assign data_out   = data_out_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_lisp_memory.sv
// Self-checking bench for lisp_memory: directed scenarios plus randomized
// reads (and writes when MEM_WRITE_EN is defined) against a word-array model.
module tb_lisp_memory;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [11:0] addr_in = '0;
`ifdef MEM_WRITE_EN
  logic        wr_req = 1'b0;
  logic [15:0] wr_data = '0;
`endif
  logic        data_ready;
  logic [15:0] data_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] model_mem [4096];

  always #5 clk = ~clk;

  lisp_memory #(
    .READ_LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr_in   (addr_in),
`ifdef MEM_WRITE_EN
    .wr_req    (wr_req),
    .wr_data   (wr_data),
`endif
    .data_ready(data_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  // Issue one read pulse and observe the response (no checking here).
  // lat = cycles from acceptance edge to data_ready, -1 if none in 20 cycles.
  task automatic issue_read(input logic [11:0] a, output int lat, output logic [15:0] d,
                            output logic busy_mid, output logic busy_at_ready,
                            output logic ready_after);
    lat = -1; d = 'x; busy_at_ready = 1'bx; ready_after = 1'bx;
    @(negedge clk);
    req = 1'b1; addr_in = a;
    @(negedge clk);
    req = 1'b0;
    busy_mid = busy;
    if (data_ready) lat = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (data_ready) begin
        lat = k; d = data_out; busy_at_ready = busy;
        @(negedge clk);
        ready_after = data_ready;
      end
    end
  endtask

`ifdef MEM_WRITE_EN
  task automatic issue_write(input logic [11:0] a, input logic [15:0] v, input logic with_req,
                             output int ready_cnt, output logic busy_seen);
    ready_cnt = 0; busy_seen = 1'b0;
    @(negedge clk);
    wr_req = 1'b1; wr_data = v; addr_in = a; req = with_req;
    @(negedge clk);
    wr_req = 1'b0; req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (data_ready) ready_cnt++;
      if (busy) busy_seen = 1'b1;
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in: got %b want 0", data_ready); end
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL reset_dout_in: got %h want 0000", data_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_in: got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (data_ready !== 1'b0 || busy !== 1'b0 || data_out !== 16'h0000) begin
      bad++; $display("FAIL reset_after: got rdy=%b busy=%b dout=%h want 0/0/0000", data_ready, busy, data_out);
    end
    $display("reset: rdy=%b busy=%b dout=%h", data_ready, busy, data_out);
  endtask

  task automatic test_single();
    int lat; logic [15:0] d; logic bm, br, ra;
    issue_read(12'h001, lat, d, bm, br, ra);
    $display("read addr=001 lat=%0d data=%h", lat, d);
    total++; if (lat != LAT) begin bad++; $display("FAIL single_lat: got %0d want %0d", lat, LAT); end
    total++; if (d !== model_mem[1]) begin bad++; $display("FAIL single_data: got %h want %h", d, model_mem[1]); end
    total++; if (bm !== 1'b1) begin bad++; $display("FAIL single_busy_mid: got %b want 1", bm); end
    total++; if (br !== 1'b0) begin bad++; $display("FAIL single_busy_fall: got %b want 0", br); end
    total++; if (ra !== 1'b0) begin bad++; $display("FAIL single_strobe_len: got %b want 0", ra); end
  endtask

  task automatic test_boundary();
    int lat; logic [15:0] d; logic bm, br, ra;
    logic [11:0] addrs [2];
    addrs[0] = 12'hFFF; addrs[1] = 12'h000;
    for (int i = 0; i < 2; i++) begin
      issue_read(addrs[i], lat, d, bm, br, ra);
      $display("read addr=%h lat=%0d data=%h", addrs[i], lat, d);
      total++; if (lat != LAT) begin bad++; $display("FAIL boundary_lat %h: got %0d want %0d", addrs[i], lat, LAT); end
      total++; if (d !== model_mem[addrs[i]]) begin bad++; $display("FAIL boundary_data %h: got %h want %h", addrs[i], d, model_mem[addrs[i]]); end
    end
  endtask

  task automatic test_drop_busy();
    int pulses = 0; logic [15:0] d = 'x;
    @(negedge clk); req = 1'b1; addr_in = 12'h005;
    @(negedge clk); addr_in = 12'h009;
    if (data_ready) begin pulses++; d = data_out; end
    @(negedge clk); req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (data_ready) begin pulses++; d = data_out; end
      @(negedge clk);
    end
    $display("drop: pulses=%0d data=%h", pulses, d);
    total++; if (pulses != 1) begin bad++; $display("FAIL drop_pulses: got %0d want 1", pulses); end
    total++; if (d !== model_mem[5]) begin bad++; $display("FAIL drop_data: got %h want %h", d, model_mem[5]); end
  endtask

  // req held high: one read per IDLE visit, re-accepted in the data_ready cycle.
  task automatic test_back_to_back();
    int t [3]; logic [15:0] dv [3]; int n = 0;
    logic [11:0] a = 12'(($urandom_range(4095, 0)));
    @(negedge clk); req = 1'b1; addr_in = a;
    for (int k = 1; k <= 40 && n < 3; k++) begin
      @(negedge clk);
      if (data_ready) begin t[n] = k; dv[n] = data_out; n++; end
    end
    req = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    $display("held req addr=%h pulses=%0d", a, n);
    total++; if (n != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", n); end
    for (int j = 0; j < n; j++) begin
      total++; if (t[j] != 1 + LAT + j * (LAT + 1)) begin
        bad++; $display("FAIL b2b_time%0d: got %0d want %0d", j, t[j], 1 + LAT + j * (LAT + 1));
      end
      total++; if (dv[j] !== model_mem[a]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", j, dv[j], model_mem[a]); end
    end
  endtask

  task automatic test_random();
    int lat; logic [15:0] d; logic bm, br, ra;
    logic [11:0] a;
    for (int i = 0; i < 24; i++) begin
      a = 12'($urandom_range(4095, 0));
`ifdef MEM_WRITE_EN
      if ($urandom_range(1, 0) == 1) begin
        int rc; logic bs; logic [15:0] v;
        v = 16'($urandom);
        issue_write(a, v, 1'b0, rc, bs);
        model_mem[a] = v;
        $display("write addr=%h data=%h rdy_pulses=%0d", a, v, rc);
        total++; if (rc != 0 || bs !== 1'b0) begin bad++; $display("FAIL rand_write %h: got rdy=%0d busy=%b want 0/0", a, rc, bs); end
      end
`endif
      issue_read(a, lat, d, bm, br, ra);
      $display("read addr=%h lat=%0d data=%h", a, lat, d);
      total++; if (lat != LAT || d !== model_mem[a]) begin
        bad++; $display("FAIL rand_read %h: got lat=%0d data=%h want lat=%0d data=%h", a, lat, d, LAT, model_mem[a]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] d; logic bm, br, ra; int pulses = 0;
    issue_read(12'h123, lat, d, bm, br, ra);
    total++; if (d !== model_mem[12'h123]) begin bad++; $display("FAIL rstmid_pre: got %h want %h", d, model_mem[12'h123]); end
    @(negedge clk); req = 1'b1; addr_in = 12'h456;
    @(negedge clk); req = 1'b0; rst = 1'b1;
    #1;
    total++; if (data_out !== 16'h0000 || busy !== 1'b0 || data_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_async: got dout=%h busy=%b rdy=%b want 0000/0/0", data_out, busy, data_ready);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (data_ready) pulses++;
    end
    $display("reset mid-read: pulses=%0d dout=%h", pulses, data_out);
    total++; if (pulses != 0) begin bad++; $display("FAIL rstmid_pulses: got %0d want 0", pulses); end
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL rstmid_dout: got %h want 0000", data_out); end
    issue_read(12'h456, lat, d, bm, br, ra);
    $display("read addr=456 lat=%0d data=%h", lat, d);
    total++; if (lat != LAT || d !== model_mem[12'h456]) begin
      bad++; $display("FAIL rstmid_fresh: got lat=%0d data=%h want lat=%0d data=%h", lat, d, LAT, model_mem[12'h456]);
    end
  endtask

`ifdef MEM_WRITE_EN
  task automatic test_write();
    int lat; logic [15:0] d; logic bm, br, ra; int rc; logic bs;
    issue_write(12'h010, 16'h1ABC, 1'b0, rc, bs);
    model_mem[12'h010] = 16'h1ABC;
    issue_read(12'h010, lat, d, bm, br, ra);
    $display("write 010=1ABC, read data=%h", d);
    total++; if (d !== 16'h1ABC) begin bad++; $display("FAIL write_read: got %h want 1abc", d); end
    issue_write(12'h020, 16'h2345, 1'b1, rc, bs);
    model_mem[12'h020] = 16'h2345;
    $display("write+req 020=2345: rdy_pulses=%0d busy=%b", rc, bs);
    total++; if (rc != 0) begin bad++; $display("FAIL write_wins_rdy: got %0d want 0", rc); end
    total++; if (bs !== 1'b0) begin bad++; $display("FAIL write_wins_busy: got %b want 0", bs); end
    issue_read(12'h020, lat, d, bm, br, ra);
    total++; if (d !== 16'h2345) begin bad++; $display("FAIL write_wins_data: got %h want 2345", d); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) model_mem[i] = 16'(i);
    test_reset();
    test_single();
    test_boundary();
    test_drop_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_WRITE_EN
    test_write();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
